// File: rtl/md_seq_if.sv
// Handshake/result bundle between the E stage and the md_seq HI/LO sequencer.
// master drives the instruction side, slave is the sequencer itself.
interface md_seq_if;
  logic        md_valid;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_is_md;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_valid, md_op, rs_val, rt_val, d_is_md,
    input  busy, stall_md, hi, lo
  );

  modport slave (
    input  md_valid, md_op, rs_val, rt_val, d_is_md,
    output busy, stall_md, hi, lo
  );
endinterface

// File: rtl/md_seq.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Define MD_SEQ_DIV_EN to build in div/divu; otherwise md_op 2-3 are reserved.
module md_seq (
  input  logic     clk,
  input  logic     rst_n,
  md_seq_if.slave  md
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;

  logic        is_mul;
  logic        is_div;
  logic        start;
  logic        busy;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [63:0] mul_res;

  always_comb begin
    is_mul = (md.md_op == 3'd0) || (md.md_op == 3'd1);
`ifdef MD_SEQ_DIV_EN
    is_div = (md.md_op == 3'd2) || (md.md_op == 3'd3);
`else
    is_div = 1'b0;
`endif
    busy  = (state_q == BUSY);
    start = md.md_valid & (is_mul | is_div) & (state_q == IDLE);
  end

  // Product is formed combinationally at start; the busy window only models latency.
  always_comb begin
    prod_s  = $signed({{32{md.rs_val[31]}}, md.rs_val}) *
              $signed({{32{md.rt_val[31]}}, md.rt_val});
    prod_u  = {32'd0, md.rs_val} * {32'd0, md.rt_val};
    mul_res = md.md_op[0] ? prod_u : prod_s;
  end

`ifdef MD_SEQ_DIV_EN
  logic               div_zero;
  logic               div_ovf;
  logic signed [31:0] sdiv_q, sdiv_r;
  logic        [31:0] udiv_q, udiv_r;
  logic        [31:0] div_q, div_r;

  // The most-negative / -1 case overflows a 32-bit quotient, so it is pinned explicitly.
  always_comb begin
    div_zero = (md.rt_val == 32'd0);
    div_ovf  = (md.rs_val == 32'h8000_0000) && (md.rt_val == 32'hFFFF_FFFF);
    sdiv_q   = '0;
    sdiv_r   = '0;
    udiv_q   = '0;
    udiv_r   = '0;
    if (!div_zero) begin
      if (div_ovf) begin
        sdiv_q = 32'sh8000_0000;
        sdiv_r = '0;
      end else begin
        sdiv_q = $signed(md.rs_val) / $signed(md.rt_val);
        sdiv_r = $signed(md.rs_val) % $signed(md.rt_val);
      end
      udiv_q = md.rs_val / md.rt_val;
      udiv_r = md.rs_val % md.rt_val;
    end
    div_q = md.md_op[0] ? udiv_q : sdiv_q;
    div_r = md.md_op[0] ? udiv_r : sdiv_r;
  end
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;

    if (state_q == IDLE) begin
      if (start) begin
        state_d = BUSY;
        if (is_mul) begin
          cnt_d     = MUL_CYCLES;
          pend_hi_d = mul_res[63:32];
          pend_lo_d = mul_res[31:0];
        end
`ifdef MD_SEQ_DIV_EN
        else begin
          cnt_d = DIV_CYCLES;
          // Divide by zero re-commits the current HI/LO so completion leaves them untouched.
          if (div_zero) begin
            pend_hi_d = hi_q;
            pend_lo_d = lo_q;
          end else begin
            pend_hi_d = div_r;
            pend_lo_d = div_q;
          end
        end
`endif
      end else if (md.md_valid && (md.md_op == 3'd4)) begin
        hi_d = md.rs_val;
      end else if (md.md_valid && (md.md_op == 3'd5)) begin
        lo_d = md.rs_val;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        state_d = IDLE;
        hi_d    = pend_hi_q;
        lo_d    = pend_lo_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // Reset gates the stall so a pending start cannot freeze the front end while in reset.
  always_comb begin
    md.busy     = busy;
    md.stall_md = rst_n & md.d_is_md & (busy | start);
    md.hi       = hi_q;
    md.lo       = lo_q;
  end

endmodule

// File: tb/tb_md_seq.sv
// Self-checking bench for md_seq: randomized ops against an arithmetic HI/LO model.
// Honours MD_SEQ_DIV_EN the same way the design does.
module tb_md_seq;

`ifdef MD_SEQ_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  md_seq_if bus ();

  md_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus)
  );

  // Reference model: applies one accepted op to exp_hi/exp_lo, returns busy length.
  function automatic int model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    case (op)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        return 5;
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        return 5;
      end
      3'd2, 3'd3: begin
        if (!DIV_EN) return 0;
        if (b == 32'd0) return 10;
        if (op == 3'd2) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
        end else begin
          sa = longint'({32'd0, a});
          sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa - q * sb;
        exp_lo = q[31:0];
        exp_hi = r[31:0];
        return 10;
      end
      3'd4: begin exp_hi = a; return 0; end
      3'd5: begin exp_lo = a; return 0; end
      default: return 0;
    endcase
  endfunction

  task automatic drive_idle();
    bus.md_valid = 1'b0;
    bus.md_op    = 3'd0;
    bus.rs_val   = '0;
    bus.rt_val   = '0;
  endtask

  // Presents one op for a single cycle; returns 1 ns after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.md_valid = 1'b1;
    bus.md_op    = op;
    bus.rs_val   = a;
    bus.rt_val   = b;
    @(posedge clk);
    #1;
    bus.md_valid = 1'b0;
  endtask

  // Counts busy cycles until idle, bounded so a stuck busy still reaches the summary.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.d_is_md  = 1'b1;
    bus.md_valid = 1'b1;
    bus.md_op    = 3'd0;
    bus.rs_val   = 32'd3;
    bus.rt_val   = 32'd3;
    #12;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", bus.lo); end
    checks++; if (bus.stall_md !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall_md); end
    drive_idle();
    bus.d_is_md = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_hi = '0;
    exp_lo = '0;
  endtask

  task automatic test_mult();
    logic [31:0] a, b;
    logic [2:0]  op;
    int n, len;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin a = 32'hFFFF_FFFE; b = 32'd3; op = 3'd0; end
      else begin a = $urandom; b = $urandom; op = 3'($urandom_range(0, 1)); end
      len = model_op(op, a, b);
      issue(op, a, b);
      wait_idle(n);
      checks++; if (n !== len) begin errors++; $display("[TB] FAIL mult_busy_len[%0d]: got %0d expected %0d", i, n, len); end
      checks++; if (bus.hi !== exp_hi) begin errors++; $display("[TB] FAIL mult_hi[%0d]: got %h expected %h", i, bus.hi, exp_hi); end
      checks++; if (bus.lo !== exp_lo) begin errors++; $display("[TB] FAIL mult_lo[%0d]: got %h expected %h", i, bus.lo, exp_lo); end
    end
  endtask

  task automatic test_div();
    logic [31:0] a, b;
    logic [2:0]  op;
    int n, len;
    issue(3'd4, 32'hA5A5_0001, 32'd0);
    issue(3'd5, 32'h5A5A_0002, 32'd0);
    void'(model_op(3'd4, 32'hA5A5_0001, 32'd0));
    void'(model_op(3'd5, 32'h5A5A_0002, 32'd0));
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin op = 3'd3; a = 32'd100;        b = 32'd7;          end
        1: begin op = 3'd2; a = 32'h8000_0000;  b = 32'hFFFF_FFFF;  end
        2: begin op = 3'd2; a = 32'd5;          b = 32'd0;          end
        3: begin op = 3'd2; a = 32'hFFFF_FFF9;  b = 32'd2;          end
        default: begin
          op = 3'($urandom_range(2, 3));
          a  = $urandom;
          b  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
        end
      endcase
      len = model_op(op, a, b);
      issue(op, a, b);
      wait_idle(n);
      checks++; if (n !== len) begin errors++; $display("[TB] FAIL div_busy_len[%0d]: got %0d expected %0d", i, n, len); end
      checks++; if (bus.hi !== exp_hi) begin errors++; $display("[TB] FAIL div_hi[%0d]: got %h expected %h", i, bus.hi, exp_hi); end
      checks++; if (bus.lo !== exp_lo) begin errors++; $display("[TB] FAIL div_lo[%0d]: got %h expected %h", i, bus.lo, exp_lo); end
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] a, b, v;
    int n, len;
    void'(model_op(3'd4, 32'h1234_5678, 32'd0));
    issue(3'd4, 32'h1234_5678, 32'hDEAD_BEEF);
    checks++; if (bus.hi !== 32'h1234_5678) begin errors++; $display("[TB] FAIL mthi_hi: got %h expected 12345678", bus.hi); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy: got %b expected 0", bus.busy); end
    v = $urandom;
    void'(model_op(3'd5, v, 32'd0));
    issue(3'd5, v, 32'd0);
    checks++; if (bus.lo !== exp_lo) begin errors++; $display("[TB] FAIL mtlo_lo: got %h expected %h", bus.lo, exp_lo); end
    a = $urandom;
    b = $urandom;
    len = model_op(3'd0, a, b);
    issue(3'd0, a, b);
    issue(3'd5, $urandom, 32'd0);
    checks++; if (bus.lo !== exp_lo_before_commit(v)) begin errors++; $display("[TB] FAIL mtlo_busy_lo: got %h expected %h", bus.lo, v); end
    wait_idle(n);
    checks++; if (n + 1 !== len) begin errors++; $display("[TB] FAIL mtlo_busy_len: got %0d expected %0d", n + 1, len); end
    checks++; if (bus.lo !== exp_lo) begin errors++; $display("[TB] FAIL mtlo_after_mult_lo: got %h expected %h", bus.lo, exp_lo); end
  endtask

  function automatic logic [31:0] exp_lo_before_commit(input logic [31:0] v);
    return v;
  endfunction

  task automatic test_reserved();
    logic [31:0] h, l;
    for (int i = 0; i < 4; i++) begin
      h = exp_hi;
      l = exp_lo;
      issue(3'(6 + (i % 2)), $urandom, $urandom);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reserved_busy[%0d]: got %b expected 0", i, bus.busy); end
      checks++; if (bus.hi !== h || bus.lo !== l) begin errors++; $display("[TB] FAIL reserved_hilo[%0d]: got %h/%h expected %h/%h", i, bus.hi, bus.lo, h, l); end
    end
  endtask

  task automatic test_stall(input logic dmd);
    logic [31:0] a, b;
    int cnt, want;
    a = $urandom;
    b = $urandom;
    void'(model_op(3'd0, a, b));
    cnt  = 0;
    want = dmd ? 6 : 0;
    bus.d_is_md  = dmd;
    bus.md_valid = 1'b1;
    bus.md_op    = 3'd0;
    bus.rs_val   = a;
    bus.rt_val   = b;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus.stall_md === 1'b1) cnt++;
      @(posedge clk);
      #1;
      bus.md_valid = 1'b0;
    end
    bus.d_is_md = 1'b0;
    checks++; if (cnt !== want) begin errors++; $display("[TB] FAIL stall_cycles_dmd%0b: got %0d expected %0d", dmd, cnt, want); end
    checks++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin errors++; $display("[TB] FAIL stall_result: got %h/%h expected %h/%h", bus.hi, bus.lo, exp_hi, exp_lo); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int n, len;
    a = $urandom;
    b = $urandom;
    len = model_op(3'd0, a, b);
    issue(3'd0, a, b);
    bus.md_valid = 1'b1;
    bus.md_op    = 3'd1;
    bus.rs_val   = $urandom;
    bus.rt_val   = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      bus.md_op = 3'($urandom_range(0, 5));
    end
    bus.md_valid = 1'b0;
    wait_idle(n);
    checks++; if (n + 3 !== len) begin errors++; $display("[TB] FAIL b2b_first_len: got %0d expected %0d", n + 3, len); end
    checks++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin errors++; $display("[TB] FAIL b2b_first_result: got %h/%h expected %h/%h", bus.hi, bus.lo, exp_hi, exp_lo); end
    a = $urandom;
    b = $urandom;
    len = model_op(3'd1, a, b);
    issue(3'd1, a, b);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second_accept: got %b expected 1", bus.busy); end
    wait_idle(n);
    checks++; if (n !== len) begin errors++; $display("[TB] FAIL b2b_second_len: got %0d expected %0d", n, len); end
    checks++; if (bus.hi !== exp_hi || bus.lo !== exp_lo) begin errors++; $display("[TB] FAIL b2b_second_result: got %h/%h expected %h/%h", bus.hi, bus.lo, exp_hi, exp_lo); end
  endtask

  task automatic test_reset_mid_op();
    void'(model_op(3'd4, 32'hCAFE_0001, 32'd0));
    issue(3'd4, 32'hCAFE_0001, 32'd0);
    issue(3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errors++; $display("[TB] FAIL midreset_hilo: got %h/%h expected 0/0", bus.hi, bus.lo); end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL postreset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errors++; $display("[TB] FAIL postreset_hilo: got %h/%h expected 0/0", bus.hi, bus.lo); end
  endtask

  initial begin
    drive_idle();
    bus.d_is_md = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_reserved();
    test_stall(1'b1);
    test_stall(1'b0);
    test_back_to_back();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_seq.md
MD_SEQ -- requirements
Module: md_seq

Interface
REQ-001 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide md_valid  input  1  E-stage multiply/divide-class instruction present this cycle.
REQ-004 SHALL provide md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved.
REQ-005 SHALL provide rs_val  input  32  forwarded rs operand.
REQ-006 SHALL provide rt_val  input  32  forwarded rt operand.
REQ-007 SHALL provide d_is_md  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-008 SHALL provide busy  output  1  mult/div operation in progress.
REQ-009 SHALL provide stall_md  output  1  freeze F/D and bubble E, combinational.
REQ-010 SHALL provide hi  output  32  architectural HI.
REQ-011 SHALL provide lo  output  32  architectural LO.

Function
REQ-012 SHALL implement FSM with states IDLE and BUSY plus 4-bit down-counter cnt.
REQ-013 SHALL define start = md_valid & (md_op <= 3) & state==IDLE.
REQ-014 On start, SHALL capture result into pend_hi/pend_lo at that edge, load cnt = 5 (mult/multu) or 10 (div/divu), enter BUSY.
REQ-015 mult: {pend_hi,pend_lo} = signed 64-bit rs_val*rt_val; multu: unsigned product.
REQ-016 div: pend_lo = signed quotient rs_val/rt_val truncated toward zero, pend_hi = remainder with sign of rs_val; divu: unsigned.
REQ-017 Signed div 0x80000000 / 0xFFFFFFFF SHALL give pend_lo=0x80000000, pend_hi=0.
REQ-018 Divide by zero SHALL load pend_hi/pend_lo with current hi/lo (HI/LO unchanged at completion); busy timing unaffected.
REQ-019 In BUSY, cnt SHALL decrement each edge; at edge where cnt==1, hi<=pend_hi, lo<=pend_lo, state<=IDLE.
REQ-020 busy SHALL equal (state==BUSY): exactly 5 cycles for mult, 10 for div, starting the cycle after start.
REQ-021 mthi/mtlo with md_valid in IDLE SHALL write rs_val to hi/lo at that edge; busy stays 0.
REQ-022 Any md_valid while BUSY, or md_op 6-7, SHALL be ignored (no state change).
REQ-023 stall_md SHALL equal d_is_md & (busy | start).
REQ-024 New start SHALL be accepted in the first cycle after completion (back-to-back, no idle gap).
REQ-025 hi/lo SHALL change only per REQ-019, REQ-021 or reset.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, cnt=0, busy=0, hi=0, lo=0, pend_hi=0, pend_lo=0.
REQ-027 Reset asserted mid-operation SHALL abort it; pending result SHALL never reach hi/lo.
REQ-028 stall_md SHALL be 0 during reset regardless of d_is_md.

Configuration
REQ-029 Macro MD_SEQ_DIV_EN defined: div/divu supported per REQ-014..REQ-018.
REQ-030 MD_SEQ_DIV_EN undefined: md_op 2-3 SHALL be treated as reserved (ignored, no busy, no stall contribution); no divider logic synthesized.

Verification
REQ-031 mult rs=0xFFFFFFFE, rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 divu rs=100, rt=7 -> busy high 10 cycles; then lo=14, hi=2; with macro undefined hi/lo unchanged, busy never rises.
REQ-033 div rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0; div rs=5, rt=0 -> hi/lo unchanged after 10 cycles.
REQ-034 d_is_md=1 during mult start and busy cycles -> stall_md=1 for 6 cycles; d_is_md=0 -> stall_md=0 throughout.
REQ-035 mthi rs=0x12345678 in IDLE -> hi=0x12345678 next cycle; mtlo issued while BUSY -> lo unchanged.
REQ-036 rst_n pulled low at cycle 3 of a mult -> busy=0, hi=lo=0 immediately, no later update after release.
